// File: rtl/icache_2way_pkg.sv
// Shared geometry, hit/miss constants and way naming for the two-way instruction cache.
// The defaults describe the IF-stage cache: 32-bit addresses and words, 64 sets.
package icache_2way_pkg;

    localparam int ICACHE_ADDR_W  = 32;
    localparam int ICACHE_INST_W  = 32;
    localparam int ICACHE_SETS    = 64;
    localparam int ICACHE_INDEX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W   = ICACHE_ADDR_W - ICACHE_INDEX_W - 2;
    localparam int ICACHE_CNT_W   = 16;

    localparam logic Hit  = 1'b1;
    localparam logic Miss = 1'b0;

    typedef enum logic {
        WAY0 = 1'b0,
        WAY1 = 1'b1
    } way_e;

endpackage

// File: rtl/icache_2way_way.sv
// One way of the instruction cache: valid/tag/data storage with a combinational lookup
// port, a second compare port at the fill index for victim selection, and a write port.
module icache_way #(
    parameter int INST_W  = 32,
    parameter int SETS    = 64,
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rdIndex_i,
    input  logic [TAG_W-1:0]   rdTag_i,
    output logic               rdHit_o,
    output logic [INST_W-1:0]  rdData_o,
    input  logic [INDEX_W-1:0] wrIndex_i,
    input  logic [TAG_W-1:0]   wrTag_i,
    output logic               wrValid_o,
    output logic               wrMatch_o,
    input  logic               we_i,
    input  logic [INST_W-1:0]  wrData_i,
    input  logic               clear_i
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tags_q [SETS];
    logic [INST_W-1:0] data_q [SETS];

    // Only the valid bits need a reset; stale tags/data are masked by valid=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wrIndex_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i && !clear_i) begin
            tags_q[wrIndex_i] <= wrTag_i;
            data_q[wrIndex_i] <= wrData_i;
        end
    end

    assign rdHit_o   = valid_q[rdIndex_i] && (tags_q[rdIndex_i] == rdTag_i);
    assign rdData_o  = data_q[rdIndex_i];
    assign wrValid_o = valid_q[wrIndex_i];
    assign wrMatch_o = valid_q[wrIndex_i] && (tags_q[wrIndex_i] == wrTag_i);

endmodule

// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache for the IF stage: combinational lookup with
// same-cycle fill bypass, LRU replacement, flush and a saturating fill counter.
module icache_2way
    import icache_2way_pkg::*;
#(
    parameter int ADDR_W  = ICACHE_ADDR_W,
    parameter int INST_W  = ICACHE_INST_W,
    parameter int SETS    = ICACHE_SETS,
    parameter int INDEX_W = ICACHE_INDEX_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       icache_raddr_i,
    output logic                    icache_hit_o,
    output logic [INST_W-1:0]       icache_inst_o,
    input  logic                    icache_we_i,
    input  logic [ADDR_W-1:0]       icache_waddr_i,
    input  logic [INST_W-1:0]       icache_winst_i,
    input  logic                    flush_i,
    output logic [ICACHE_CNT_W-1:0] fill_cnt_o
);

    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    logic [INDEX_W-1:0]      rdIndex;
    logic [INDEX_W-1:0]      wrIndex;
    logic [TAG_W-1:0]        rdTag;
    logic [TAG_W-1:0]        wrTag;
    logic [1:0]              wayHit;
    logic [1:0]              wayValid;
    logic [1:0]              wayMatch;
    logic [1:0]              wayWe;
    logic [INST_W-1:0]       wayData [2];
    logic                    arrayHit;
    logic                    bypassHit;
    logic                    fillEn;
    way_e                    hitWay;
    way_e                    victim;
    logic [SETS-1:0]         lru_q;
    logic [SETS-1:0]         lru_d;
    logic [ICACHE_CNT_W-1:0] fillCnt_q;
    logic [ICACHE_CNT_W-1:0] fillCnt_d;
    logic                    unusedLowBits;

    assign rdIndex = icache_raddr_i[INDEX_W+1:2];
    assign rdTag   = icache_raddr_i[ADDR_W-1:INDEX_W+2];
    assign wrIndex = icache_waddr_i[INDEX_W+1:2];
    assign wrTag   = icache_waddr_i[ADDR_W-1:INDEX_W+2];
    assign unusedLowBits = ^{icache_raddr_i[1:0], icache_waddr_i[1:0]};

    assign fillEn    = icache_we_i && !flush_i;
    assign bypassHit = icache_we_i && (icache_waddr_i[ADDR_W-1:2] == icache_raddr_i[ADDR_W-1:2]);
    assign arrayHit  = |wayHit;
    assign hitWay    = wayHit[1] ? WAY1 : WAY0;

    for (genvar w = 0; w < 2; w++) begin : g_way
        assign wayWe[w] = fillEn && (victim == way_e'(w));

        icache_way #(
            .INST_W  (INST_W),
            .SETS    (SETS),
            .INDEX_W (INDEX_W),
            .TAG_W   (TAG_W)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .rdIndex_i (rdIndex),
            .rdTag_i   (rdTag),
            .rdHit_o   (wayHit[w]),
            .rdData_o  (wayData[w]),
            .wrIndex_i (wrIndex),
            .wrTag_i   (wrTag),
            .wrValid_o (wayValid[w]),
            .wrMatch_o (wayMatch[w]),
            .we_i      (wayWe[w]),
            .wrData_i  (icache_winst_i),
            .clear_i   (flush_i)
        );
    end

    // Re-filling a resident tag reuses its way so the set never holds a duplicate.
    always_comb begin
        victim = way_e'(lru_q[wrIndex]);
        if (wayMatch[0]) begin
            victim = WAY0;
        end else if (wayMatch[1]) begin
            victim = WAY1;
        end else if (!wayValid[0]) begin
            victim = WAY0;
        end else if (!wayValid[1]) begin
            victim = WAY1;
        end
    end

    always_comb begin
        icache_hit_o  = Miss;
        icache_inst_o = '0;
        if (rst) begin
            if (bypassHit) begin
                icache_hit_o  = Hit;
                icache_inst_o = icache_winst_i;
            end else if (arrayHit) begin
                icache_hit_o  = Hit;
                icache_inst_o = wayData[hitWay];
            end
        end
    end

    // The fill update is applied last so it wins when both touch the same set.
    always_comb begin
        lru_d = lru_q;
        if (flush_i) begin
            lru_d = '0;
        end else begin
            if (arrayHit) begin
                lru_d[rdIndex] = ~hitWay;
            end
            if (fillEn) begin
                lru_d[wrIndex] = ~victim;
            end
        end
    end

    always_comb begin
        fillCnt_d = fillCnt_q;
        if (fillEn && (fillCnt_q != '1)) begin
            fillCnt_d = fillCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lru_q     <= '0;
            fillCnt_q <= '0;
        end else begin
            lru_q     <= lru_d;
            fillCnt_q <= fillCnt_d;
        end
    end

    assign fill_cnt_o = fillCnt_q;

endmodule

// File: tb/tb_icache_2way.sv
// Self-checking bench for icache_2way: expected hit/inst/fill count per cycle are queued
// when a cycle is driven and compared against the DUT on the following falling edge.
`timescale 1ns/1ps
module tb_icache_2way;

    localparam logic [31:0] PARK = 32'h8000_0FC0;

    typedef struct {
        logic        hit;
        logic [31:0] inst;
        logic [15:0] cnt;
    } expT;

    logic        clk;
    logic        rst;
    logic [31:0] raddr;
    logic        hit;
    logic [31:0] inst;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] winst;
    logic        flush;
    logic [15:0] fillCnt;

    expT scoreboard[$];
    int  total;
    int  bad;

    icache_2way dut (
        .clk            (clk),
        .rst            (rst),
        .icache_raddr_i (raddr),
        .icache_hit_o   (hit),
        .icache_inst_o  (inst),
        .icache_we_i    (we),
        .icache_waddr_i (waddr),
        .icache_winst_i (winst),
        .flush_i        (flush),
        .fill_cnt_o     (fillCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle starting just after a rising edge, checks at the falling edge,
    // then lets the rising edge commit and returns to the idle input state.
    task automatic applyStimulus(input string tag, input logic [31:0] ra, input logic doWe,
                                 input logic [31:0] wa, input logic [31:0] wd, input logic doFlush,
                                 input logic expHit, input logic [31:0] expInst, input logic [15:0] expCnt);
        expT e;
        expT got;
        raddr = ra;
        we    = doWe;
        waddr = wa;
        winst = wd;
        flush = doFlush;
        e.hit  = expHit;
        e.inst = expInst;
        e.cnt  = expCnt;
        scoreboard.push_back(e);
        @(negedge clk);
        if (scoreboard.size() == 0) begin
            checkOutput({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = scoreboard.pop_front();
            checkOutput({tag, ".hit"}, {31'd0, hit}, {31'd0, got.hit});
            checkOutput({tag, ".inst"}, inst, got.inst);
            checkOutput({tag, ".cnt"}, {16'd0, fillCnt}, {16'd0, got.cnt});
        end
        @(posedge clk);
        #1;
        we    = 1'b0;
        flush = 1'b0;
        raddr = PARK;
    endtask

    task automatic fillLine(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [15:0] expCnt);
        applyStimulus(tag, PARK, 1'b1, a, d, 1'b0, 1'b0, 32'd0, expCnt);
    endtask

    task automatic lookupLine(input string tag, input logic [31:0] a, input logic expHit,
                              input logic [31:0] expInst, input logic [15:0] expCnt);
        applyStimulus(tag, a, 1'b0, 32'd0, 32'd0, 1'b0, expHit, expInst, expCnt);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        raddr = PARK;
        we    = 1'b0;
        waddr = 32'd0;
        winst = 32'd0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        lookupLine("rst_lookup", 32'h100, 1'b0, 32'd0, 16'd0);
        applyStimulus("rst_bypass", 32'h204, 1'b1, 32'h204, 32'h1234_5678, 1'b0, 1'b0, 32'd0, 16'd0);
        rst = 1'b1;
        lookupLine("rst_fill_lost", 32'h204, 1'b0, 32'd0, 16'd0);

        fillLine("fill_100", 32'h100, 32'h0050_0093, 16'd0);
        lookupLine("read_100", 32'h100, 1'b1, 32'h0050_0093, 16'd1);
        applyStimulus("bypass_204", 32'h204, 1'b1, 32'h204, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 16'd1);
        lookupLine("read_204", 32'h204, 1'b1, 32'h1234_5678, 16'd2);

        applyStimulus("flush_all", PARK, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 16'd2);
        lookupLine("flushed_100", 32'h100, 1'b0, 32'd0, 16'd2);

        fillLine("fill_000", 32'h000, 32'hA000_0000, 16'd2);
        fillLine("fill_100b", 32'h100, 32'hA100_0100, 16'd3);
        lookupLine("touch_000", 32'h000, 1'b1, 32'hA000_0000, 16'd4);
        fillLine("fill_200", 32'h200, 32'hA200_0200, 16'd4);
        lookupLine("keep_000", 32'h000, 1'b1, 32'hA000_0000, 16'd5);
        lookupLine("new_200", 32'h200, 1'b1, 32'hA200_0200, 16'd5);
        lookupLine("evict_100", 32'h100, 1'b0, 32'd0, 16'd5);

        lookupLine("touch_000b", 32'h000, 1'b1, 32'hA000_0000, 16'd5);
        fillLine("refill_000", 32'h000, 32'hDEAD_BEEF, 16'd5);
        lookupLine("refilled_000", 32'h000, 1'b1, 32'hDEAD_BEEF, 16'd6);
        lookupLine("other_200", 32'h200, 1'b1, 32'hA200_0200, 16'd6);

        fillLine("fill_300", 32'h300, 32'h3300_0300, 16'd6);
        lookupLine("read_300", 32'h300, 1'b1, 32'h3300_0300, 16'd7);
        applyStimulus("flush_fill_304", 32'h304, 1'b1, 32'h304, 32'h3400_0304, 1'b1, 1'b1, 32'h3400_0304, 16'd7);
        lookupLine("flushed_300", 32'h300, 1'b0, 32'd0, 16'd7);
        lookupLine("flushed_304", 32'h304, 1'b0, 32'd0, 16'd7);

        fillLine("prio_fill_000", 32'h000, 32'hB000_0000, 16'd7);
        fillLine("prio_fill_100", 32'h100, 32'hB100_0100, 16'd8);
        applyStimulus("prio_hit_fill", 32'h100, 1'b1, 32'h200, 32'hB200_0200, 1'b0, 1'b1, 32'hB100_0100, 16'd9);
        fillLine("prio_fill_300", 32'h300, 32'hB300_0300, 16'd10);
        lookupLine("prio_200", 32'h200, 1'b1, 32'hB200_0200, 16'd11);
        lookupLine("prio_100", 32'h100, 1'b0, 32'd0, 16'd11);
        lookupLine("prio_300", 32'h300, 1'b1, 32'hB300_0300, 16'd11);

        rst = 1'b0;
        lookupLine("reset_mid", 32'h300, 1'b0, 32'd0, 16'd0);
        rst = 1'b1;

        raddr = PARK;
        waddr = 32'h1000;
        winst = 32'h0000_0013;
        we    = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        we = 1'b0;
        lookupLine("cnt_fffe", PARK, 1'b0, 32'd0, 16'hFFFE);
        we = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        we = 1'b0;
        lookupLine("cnt_sat", PARK, 1'b0, 32'd0, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
